serial_adder: RTL and testbench

- Bit-serial N-bit adder: one full-adder cell, one bit per clock, LSB first, with a start/done handshake.
- Area-cheap counterpart to the combinational subtracter blocks. It covers the add direction where latency is acceptable and one adder cell replaces N.
- Used in datapaths that accept a multi-cycle sum and want a registered result with carry-out.

---
 rtl/serial_arith_pkg.sv | 29 ++
 rtl/serial_adder_if.sv | 32 +++
 rtl/full_adder_cell.sv | 23 ++
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared state encodings and sizing helpers for bit-serial
//                arithmetic blocks (serial adder, future serial subtracter).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    // Raw encodings; the unused code 2'd3 is decoded as IDLE by consumers.
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = C_ST_IDLE,
        S_RUN  = C_ST_RUN,
        S_DONE = C_ST_DONE
    } state_t;

    // Width of a bit counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================================
//  Module      : serial_adder_if
//  Description : Start/done handshake and operand/result bus of the serial
//                adder. The master issues operations, the slave computes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         co;

    modport master (
        output start, a, b, ci,
        input  busy, done, sum, co
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, sum, co
    );
endinterface

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
//  Module      : full_adder_cell
//  Description : Single-bit combinational full adder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  wire logic x,
    input  wire logic y,
    input  wire logic c,
    output logic      s,
    output logic      cout
);
    logic w_p;

    // Propagate term shared by the sum and the carry.
    assign w_p  = x ^ y;
    assign s    = w_p ^ c;
    assign cout = (x & y) | (c & w_p);
endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial N-bit adder, LSB first, one full-adder cell,
//                N cycles per operation, registered sum and carry-out.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    serial_adder_if.slave  bus
);
    localparam int CW = cnt_width(N);

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_res;
    logic [N-1:0]    w_res_next;
    logic [N-1:0]    r_sum;
    logic            r_co;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic            w_s;
    logic            w_cout;

    assign w_last = (r_cnt == CW'(N - 1));

    // The single adder cell consumes the current LSBs and the carry flop.
    full_adder_cell u_fa (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .c    (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // New sum bit enters at the MSB; after N steps the register is complete.
    generate
        if (N == 1) begin : g_res_one
            assign w_res_next = w_s;
        end else begin : g_res_multi
            logic w_unused_lsb;
            assign w_unused_lsb = r_res[0];
            assign w_res_next   = {w_s, r_res[N-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control; start is only honoured when not busy.
    always_comb begin
        w_next = S_IDLE;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_RUN: begin
                w_step = 1'b1;
                w_next = w_last ? S_DONE : S_RUN;
            end
            // IDLE, DONE and the unused encoding all accept a new start.
            default: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
        endcase
    end

    // Operand capture, bit-serial shifting and completion-edge result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.ci;
            r_res   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum <= w_res_next;
                r_co  <= w_cout;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.co   = r_co;
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder at N=8, N=1 and N=13.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.N(8))  if8 ();
    serial_adder_if #(.N(1))  if1 ();
    serial_adder_if #(.N(13)) if13 ();

    serial_adder #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.N(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.N(13)) dut13 (.clk(clk), .rst(rst), .bus(if13));

    // Reference: {co,sum} = a + b + ci truncated to n+1 bits, operands to n bits.
    function automatic logic [13:0] model(input int n, input logic [12:0] a,
                                          input logic [12:0] b, input logic ci);
        logic [13:0] m;
        m = (14'd1 << n) - 14'd1;
        return (({1'b0, a} & m) + ({1'b0, b} & m) + {13'd0, ci}) & ((m << 1) | 14'd1);
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return if1.busy;
            8:       return if8.busy;
            default: return if13.busy;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1:       return if1.done;
            8:       return if8.done;
            default: return if13.done;
        endcase
    endfunction

    function automatic logic [12:0] get_sum(input int w);
        case (w)
            1:       return {12'd0, if1.sum};
            8:       return {5'd0, if8.sum};
            default: return if13.sum;
        endcase
    endfunction

    function automatic logic get_co(input int w);
        case (w)
            1:       return if1.co;
            8:       return if8.co;
            default: return if13.co;
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic [12:0] a,
                         input logic [12:0] b, input logic ci);
        case (w)
            1:       begin if1.start = st;  if1.a = a[0];     if1.b = b[0];     if1.ci = ci;  end
            8:       begin if8.start = st;  if8.a = a[7:0];   if8.b = b[7:0];   if8.ci = ci;  end
            default: begin if13.start = st; if13.a = a;       if13.b = b;       if13.ci = ci; end
        endcase
    endtask

    // Issue one operation and wait (bounded) for done; lat = edges after E0.
    task automatic run_op(input int w, input logic [12:0] a, input logic [12:0] b,
                          input logic ci, output logic [12:0] s, output logic c,
                          output int lat, output logic busy0);
        drive(w, 1'b1, a, b, ci);
        @(posedge clk); #1;
        drive(w, 1'b0, 13'($urandom), 13'($urandom), 1'($urandom));
        busy0 = get_busy(w);
        lat   = 0;
        while (!get_done(w) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        s = get_sum(w);
        c = get_co(w);
    endtask

    task automatic test_reset;
        int ws[3] = '{1, 8, 13};
        rst = 1'b1;
        drive(1, 1'b0, 13'd0, 13'd0, 1'b0);
        drive(8, 1'b0, 13'd0, 13'd0, 1'b0);
        drive(13, 1'b0, 13'd0, 13'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        foreach (ws[i]) begin
            checks++;
            if (get_busy(ws[i]) !== 1'b0 || get_done(ws[i]) !== 1'b0 ||
                get_sum(ws[i]) !== 13'd0 || get_co(ws[i]) !== 1'b0) begin
                errors++;
                $display("FAIL reset_n%0d: busy=%b done=%b sum=%h co=%b, expected all zero",
                         ws[i], get_busy(ws[i]), get_done(ws[i]), get_sum(ws[i]), get_co(ws[i]));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [13:0] exp;
        exp = model(8, 13'h5A, 13'h3C, 1'b0);
        drive(8, 1'b1, 13'h5A, 13'h3C, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 13'h0, 13'h0, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if (if8.busy !== (k < 8) || if8.done !== (k == 8)) begin
                errors++;
                $display("FAIL basic_timing after E%0d: busy=%b done=%b, expected busy=%b done=%b",
                         k, if8.busy, if8.done, (k < 8), (k == 8));
            end
            if (k == 8 || k == 9) begin
                checks++;
                if ({if8.co, if8.sum} !== exp[8:0]) begin
                    errors++;
                    $display("FAIL basic_sum after E%0d: co/sum=%h, expected %h", k, {if8.co, if8.sum}, exp[8:0]);
                end
            end
        end
    endtask

    task automatic test_carry;
        logic [12:0] av[2] = '{13'hFF, 13'hFF};
        logic [12:0] bv[2] = '{13'h01, 13'hFF};
        logic        cv[2] = '{1'b0, 1'b1};
        logic [12:0] s;
        logic        c, b0;
        int          lat;
        logic [13:0] exp;
        foreach (av[i]) begin
            exp = model(8, av[i], bv[i], cv[i]);
            run_op(8, av[i], bv[i], cv[i], s, c, lat, b0);
            checks++;
            if ({c, s[7:0]} !== exp[8:0] || lat != 8) begin
                errors++;
                $display("FAIL carry_%0d: co/sum=%h lat=%0d, expected %h lat=8", i, {c, s[7:0]}, lat, exp[8:0]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int   k;
        logic [13:0] exp;
        exp = model(8, 13'h5A, 13'h3C, 1'b0);
        drive(8, 1'b1, 13'h5A, 13'h3C, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 13'h0, 13'h0, 1'b0);
        k = 0;
        while (!if8.done && k < 60) begin
            if (k == 2) drive(8, 1'b1, 13'h11, 13'h22, 1'b0);
            if (k == 5) drive(8, 1'b0, 13'h11, 13'h22, 1'b0);
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if ({if8.co, if8.sum} !== exp[8:0] || k != 8) begin
            errors++;
            $display("FAIL ignore_start: co/sum=%h lat=%0d, expected %h lat=8", {if8.co, if8.sum}, k, exp[8:0]);
        end
        @(posedge clk); #1;
        // Next operation: the old result must hold through its RUN phase.
        drive(8, 1'b1, 13'h01, 13'h01, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 13'h0, 13'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({if8.co, if8.sum} !== exp[8:0] || if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL sum_hold: co/sum=%h busy=%b, expected %h busy=1", {if8.co, if8.sum}, if8.busy, exp[8:0]);
        end
        k = 0;
        while (!if8.done && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        exp = model(8, 13'h01, 13'h01, 1'b0);
        checks++;
        if ({if8.co, if8.sum} !== exp[8:0]) begin
            errors++;
            $display("FAIL hold_next: co/sum=%h, expected %h", {if8.co, if8.sum}, exp[8:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [12:0] s;
        logic        c, b0;
        int          lat;
        logic [13:0] exp;
        run_op(8, 13'h5A, 13'h3C, 1'b0, s, c, lat, b0);
        // Still in the DONE cycle here: issue the next start immediately.
        exp = model(8, 13'h80, 13'h80, 1'b0);
        run_op(8, 13'h80, 13'h80, 1'b0, s, c, lat, b0);
        checks++;
        if (b0 !== 1'b1 || lat + 1 != 9 || {c, s[7:0]} !== exp[8:0]) begin
            errors++;
            $display("FAIL back_to_back: busy0=%b gap=%0d co/sum=%h, expected busy0=1 gap=9 %h",
                     b0, lat + 1, {c, s[7:0]}, exp[8:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [12:0] s;
        logic        c, b0;
        int          lat;
        logic        saw;
        run_op(8, 13'hF0, 13'h34, 1'b1, s, c, lat, b0);
        @(posedge clk); #1;
        drive(8, 1'b1, 13'hC3, 13'h5D, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b0, 13'h0, 13'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.sum !== 8'd0 || if8.co !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h co=%b, expected all zero",
                     if8.busy, if8.done, if8.sum, if8.co);
        end
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.done) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done seen=%b, expected 0", saw);
        end
    endtask

    task automatic test_n1;
        logic [12:0] s;
        logic        c, b0;
        int          lat;
        logic [13:0] exp;
        for (int v = 7; v >= 0; v--) begin
            exp = model(1, 13'(v[2]), 13'(v[1]), v[0]);
            run_op(1, 13'(v[2]), 13'(v[1]), v[0], s, c, lat, b0);
            checks++;
            if ({c, s[0]} !== exp[1:0] || lat != 1) begin
                errors++;
                $display("FAIL n1 a=%0d b=%0d ci=%0d: co/sum=%b lat=%0d, expected %b lat=1",
                         v[2], v[1], v[0], {c, s[0]}, lat, exp[1:0]);
            end
        end
    endtask

    task automatic test_random(input int w, input int count);
        logic [12:0] a, b, s;
        logic        ci, c, b0;
        int          lat;
        logic [13:0] exp, got, m;
        m = (14'd1 << (w + 1)) - 14'd1;
        for (int i = 0; i < count; i++) begin
            a   = 13'($urandom);
            b   = 13'($urandom);
            ci  = 1'($urandom);
            exp = model(w, a, b, ci);
            run_op(w, a, b, ci, s, c, lat, b0);
            got = (({1'b0, s}) | ({13'd0, c} << w)) & m;
            checks++;
            if (got !== exp || lat != w) begin
                errors++;
                $display("FAIL random_n%0d #%0d a=%h b=%h ci=%b: co/sum=%h lat=%0d, expected %h lat=%0d",
                         w, i, a, b, ci, got, lat, exp, w);
            end
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_n1();
        test_random(8, 25);
        test_random(13, 25);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
